chain_step_scheduler: RTL
=========================

# chain_step_scheduler

Frame-level sequencer for the rope simulation array. It replaces the free-running one-hot rotation inside each core with a deterministic per-frame schedule: mouse capture, node integration, ITERS constraint-relaxation sweeps, then a boundary exchange. It sits above the NUM_CORES node cores, broadcasting slot enables and a core mask to all of them.

## Interface
- NUM_CORES, 4, number of cores driven; core index 0 is the first core in the chain.
- NODES_PER_CORE, 5, node slots per core.
- ITERS, 8, constraint sweeps per frame (≥1).
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low.
- frame_start  in  1  request one frame; sampled only in IDLE.
- stall  in  1  freezes INTEGRATE/CONSTRAIN progress while high.
- integrate_en  out  NODES_PER_CORE  one-hot position-update enable.
- constrain_en  out  NODES_PER_CORE  one-hot constraint enable.
- core_mask  out  NUM_CORES  cores allowed to act on this cycle's enables.
- mouse_latch  out  1  one-cycle pulse; cores capture x_mouse/y_mouse.
- boundary_latch  out  1  one-cycle pulse; cores register neighbour first/last positions.
- iter  out  8  current sweep index, 0..ITERS-1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at frame end.
- overrun_cnt  out  8  rejected frame_start count, saturating.

## Operation
- States: IDLE → MOUSE → INTEGRATE → CONSTRAIN → SYNC → DONE → IDLE.
- IDLE: all enables 0. frame_start=1 moves to MOUSE; otherwise stay.
- MOUSE: mouse_latch=1 for exactly one cycle.
- INTEGRATE: slot counter s=0..NODES_PER_CORE-1, one cycle per slot; integrate_en=1<<s, core_mask all ones.
- CONSTRAIN: iter=0..ITERS-1; within each sweep, s=0..NODES_PER_CORE-1; constrain_en=1<<s. Parity sub-phase per Configuration.
- SYNC: boundary_latch=1, one cycle. DONE: done=1, one cycle, iter cleared.
- stall=1 in INTEGRATE/CONSTRAIN: counters and state hold, integrate_en/constrain_en/core_mask forced 0; progress resumes on the first cycle stall=0. stall ignored in other states.
- frame_start=1 in any state but IDLE (including DONE): not accepted; overrun_cnt += 1, saturating at 255.
- Counter widths: slot counter clog2(NODES_PER_CORE) bits, wraps to 0 at sweep end; iter increments only on slot wrap.

## Timing
- Reset (reset=0 at an edge): next cycle state IDLE, every output 0, including overrun_cnt and iter. Applies mid-frame; no partial done.
- frame_start sampled at edge t ⇒ mouse_latch high cycle t+1; integrate cycles t+2..t+1+N (N=NODES_PER_CORE); K=ITERS·N·P constrain cycles (P=2 with macro, else 1); boundary_latch at t+2+N+K; done at t+3+N+K; busy deasserts at t+4+N+K. Each stall cycle adds one.
- Defaults: done at t+48 without macro, t+88 with macro.
- New frame_start accepted no earlier than the cycle after DONE; back-to-back frames give one idle cycle between done and next mouse_latch.
- All outputs registered; no combinational input-to-output path.

## Configuration
- SCHED_PARITY_SPLIT_EN defined: each constrain slot takes two cycles: first with core_mask = even-indexed cores, second with odd-indexed cores, so neighbouring cores never relax adjacent boundary nodes simultaneously; P=2.
- Undefined: one cycle per slot, core_mask all ones; P=1.

## Test plan
- Reset mid-CONSTRAIN (iter=3) → next cycle all outputs 0, busy=0; following frame_start completes normally with done at t+48.
- Single frame, defaults, no macro → mouse_latch at t+1, integrate_en 00001..10000 at t+2..t+6, 40 constrain cycles, boundary_latch t+47, done t+48.
- Macro defined, NUM_CORES=4 → each constrain slot shows core_mask 0101 then 1010; done at t+88.
- stall held 3 cycles during INTEGRATE slot 2 → enables 0 for those cycles, integrate_en resumes at 00100, done at t+51.
- frame_start held high continuously for 3 frames → overrun_cnt counts every busy cycle, saturates at 255 after enough frames; frames spaced by one idle cycle.
- ITERS=1, NODES_PER_CORE=2 → iter stays 0, done at t+7.

Source files
------------

// File: rtl/chain_step_scheduler.sv
// chain_step_scheduler: per-frame sequencer for the rope core array.
// Each frame runs in this order: mouse capture, node integration, ITERS
// constraint sweeps, boundary exchange, then a done pulse. The slot enables
// and the core mask are broadcast to all NUM_CORES node cores.
//
// Optional build macro SCHED_PARITY_SPLIT_EN: every constraint slot is split
// into two cycles. The first cycle enables the even-indexed cores and the
// second enables the odd-indexed cores, so that neighbouring cores never
// relax adjacent boundary nodes at the same time. If the macro is not
// defined, each slot takes one cycle with all cores enabled.
//
// Every output is a register. The state register names the phase that is on
// the outputs in the current cycle. Each edge works out the outputs for the
// next cycle from that phase and from the slot/sweep counters. In
// INTEGRATE/CONSTRAIN the counters hold the step that is currently showing,
// or the step shown last before a stall.
module chain_step_scheduler #(
  parameter int NUM_CORES      = 4,
  parameter int NODES_PER_CORE = 5,
  parameter int ITERS          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_start,
  input  logic                      stall,
  output logic [NODES_PER_CORE-1:0] integrate_en,
  output logic [NODES_PER_CORE-1:0] constrain_en,
  output logic [NUM_CORES-1:0]      core_mask,
  output logic                      mouse_latch,
  output logic                      boundary_latch,
  output logic [7:0]                iter,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                overrun_cnt
);

  localparam int SW = (NODES_PER_CORE > 1) ? $clog2(NODES_PER_CORE) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(NODES_PER_CORE - 1);
  localparam logic [7:0]    ITER_LAST = 8'(ITERS - 1);
  localparam logic [NUM_CORES-1:0] MASK_ALL = '1;

  // Mask selecting the even cores (odd=0) or the odd cores (odd=1).
  function automatic logic [NUM_CORES-1:0] parity_mask(input logic odd);
    logic [NUM_CORES-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_CORES; i++) m[i] = (i[0] == odd);
    return m;
  endfunction

`ifdef SCHED_PARITY_SPLIT_EN
  localparam logic                 PARITY = 1'b1;
  localparam logic [NUM_CORES-1:0] MASK_A = parity_mask(1'b0);
`else
  localparam logic                 PARITY = 1'b0;
  localparam logic [NUM_CORES-1:0] MASK_A = MASK_ALL;
`endif
  localparam logic [NUM_CORES-1:0] MASK_B = parity_mask(1'b1);

  function automatic logic [NODES_PER_CORE-1:0] onehot(input logic [SW-1:0] s);
    return NODES_PER_CORE'(1) << s;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE, S_MOUSE, S_INTEGRATE, S_CONSTRAIN, S_SYNC, S_DONE
  } state_t;

  state_t        state;
  logic [SW-1:0] slot;
  logic          phase;
  logic          last_half;

  // Without the parity split every slot counts as its own last half.
  assign last_half = phase | ~PARITY;

  // Frame sequencer: next state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= S_IDLE;
      slot           <= '0;
      phase          <= 1'b0;
      integrate_en   <= '0;
      constrain_en   <= '0;
      core_mask      <= '0;
      mouse_latch    <= 1'b0;
      boundary_latch <= 1'b0;
      iter           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      overrun_cnt    <= '0;
    end else begin
      // The pulses and enables are low unless the case below sets them for the next cycle.
      integrate_en   <= '0;
      constrain_en   <= '0;
      core_mask      <= '0;
      mouse_latch    <= 1'b0;
      boundary_latch <= 1'b0;
      done           <= 1'b0;

      if (state != S_IDLE && frame_start && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;

      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state       <= S_MOUSE;
            mouse_latch <= 1'b1;
            busy        <= 1'b1;
            slot        <= '0;
            phase       <= 1'b0;
            iter        <= '0;
          end
        end

        // stall has no effect here. The first integrate slot always goes out on this edge.
        S_MOUSE: begin
          state        <= S_INTEGRATE;
          slot         <= '0;
          integrate_en <= onehot('0);
          core_mask    <= MASK_ALL;
        end

        S_INTEGRATE: begin
          if (!stall) begin
            if (slot == SLOT_LAST) begin
              state        <= S_CONSTRAIN;
              slot         <= '0;
              phase        <= 1'b0;
              constrain_en <= onehot('0);
              core_mask    <= MASK_A;
            end else begin
              slot         <= slot + 1'b1;
              integrate_en <= onehot(slot + 1'b1);
              core_mask    <= MASK_ALL;
            end
          end
        end

        S_CONSTRAIN: begin
          if (!stall) begin
            if (!last_half) begin
              // Second half of a split slot: same node, odd cores.
              phase        <= 1'b1;
              constrain_en <= onehot(slot);
              core_mask    <= MASK_B;
            end else if (slot != SLOT_LAST) begin
              slot         <= slot + 1'b1;
              phase        <= 1'b0;
              constrain_en <= onehot(slot + 1'b1);
              core_mask    <= MASK_A;
            end else if (iter != ITER_LAST) begin
              slot         <= '0;
              phase        <= 1'b0;
              iter         <= iter + 8'd1;
              constrain_en <= onehot('0);
              core_mask    <= MASK_A;
            end else begin
              state          <= S_SYNC;
              slot           <= '0;
              phase          <= 1'b0;
              boundary_latch <= 1'b1;
            end
          end
        end

        S_SYNC: begin
          state <= S_DONE;
          done  <= 1'b1;
          iter  <= '0;
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
